// File: rtl/dmc_decode_adaptive.sv
// dmc_decode_adaptive: DMC edge-interval decoder with adaptive short/long
// threshold, code-violation and range checking, idle-timeout frame end and
// a valid/ready bit output stream.
// Optional statistics counters: define DMC_DEC_STATS_EN.
module dmc_decode_adaptive #(
    parameter int DATA_W       = 6,
    parameter int AVG_LOG2     = 3,
    parameter int TIMEOUT_W    = 8,
    parameter int IDLE_TIMEOUT = 64
`ifdef DMC_DEC_STATS_EN
    ,
    parameter int STAT_W       = 16
`endif
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              enable,
    input  logic              adapt_en,
    input  logic [DATA_W-1:0] cfg_thr,
    input  logic [DATA_W-1:0] cfg_min,
    input  logic [DATA_W-1:0] cfg_max,
    input  logic [DATA_W:0]   cfg_margin,
    input  logic [DATA_W-1:0] tdc_data,
    input  logic              tdc_valid,
    output logic              tdc_ready,
    output logic              bit_data,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              frame_active,
    output logic              frame_done,
    output logic              code_err,
    output logic [DATA_W-1:0] thr_cur
`ifdef DMC_DEC_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_bits,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    // Handshake: a sample moves when tdc_valid && tdc_ready; a bit moves when
    // bit_valid && bit_ready, and bit_valid/bit_data hold until it does.

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int WIN_N = 1 << AVG_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_BIT, ST_HALF, ST_FLUSH} state_t;

    state_t                state_q, state_d;
    logic                  bit_valid_q, bit_valid_d;
    logic                  bit_data_q, bit_data_d;
    logic                  code_err_q, code_err_d;
    logic                  frame_done_q, frame_done_d;
    logic [TIMEOUT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [DATA_W-1:0]     thr_q, thr_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [AVG_LOG2:0]     win_q, win_d;
    logic                  init_q, init_d;

    logic                  accept, range_err, is_long;
    logic [DATA_W-1:0]     avg, avg_q4, thr_new;
    logic signed [DATA_W+1:0] thr_sum;

    // init_q keeps the input side closed until cfg_thr has been loaded
    assign tdc_ready    = enable && init_q && (!bit_valid_q || bit_ready) && (state_q != ST_FLUSH);
    assign accept       = tdc_valid && tdc_ready;
    assign range_err    = (tdc_data < cfg_min) || (tdc_data > cfg_max);
    assign is_long      = tdc_data > thr_q;
    assign bit_valid    = bit_valid_q;
    assign bit_data     = bit_data_q;
    assign code_err     = code_err_q;
    assign frame_done   = frame_done_q;
    assign frame_active = (state_q != ST_IDLE);
    assign thr_cur      = thr_q;

    // Decoder FSM: next state, bit emission, error/frame pulses, idle timer
    always_comb begin
        state_d      = state_q;
        bit_valid_d  = bit_valid_q;
        bit_data_d   = bit_data_q;
        code_err_d   = 1'b0;
        frame_done_d = 1'b0;
        idle_cnt_d   = idle_cnt_q;
        if (bit_valid_q && bit_ready) bit_valid_d = 1'b0;
        if (accept && range_err) code_err_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (accept && !range_err) begin
                    if (is_long) begin
                        bit_valid_d = 1'b1;
                        bit_data_d  = 1'b1;
                        state_d     = ST_BIT;
                    end else begin
                        state_d = ST_HALF;
                    end
                end
            end
            ST_BIT, ST_HALF: begin
                if (!enable) begin
                    // enable loss wins over a same-cycle timeout
                    state_d    = ST_FLUSH;
                    idle_cnt_d = '0;
                end else if (accept) begin
                    idle_cnt_d = '0;
                    if (!range_err) begin
                        if (state_q == ST_BIT) begin
                            if (is_long) begin
                                bit_valid_d = 1'b1;
                                bit_data_d  = 1'b1;
                            end else begin
                                state_d = ST_HALF;
                            end
                        end else begin
                            state_d = ST_BIT;
                            if (is_long) begin
                                // long after a half-bit: violation, resync
                                code_err_d = 1'b1;
                            end else begin
                                bit_valid_d = 1'b1;
                                bit_data_d  = 1'b0;
                            end
                        end
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + TIMEOUT_W'(1);
                    if (idle_cnt_d == TIMEOUT_W'(IDLE_TIMEOUT)) begin
                        state_d    = ST_FLUSH;
                        idle_cnt_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                idle_cnt_d = '0;
                if (!bit_valid_q) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Adaptive threshold: average a window of long samples, apply 3/4 + margin
    always_comb begin
        avg     = acc_q[ACC_W-1:AVG_LOG2];
        avg_q4  = avg >> 2;
        thr_sum = $signed({2'b00, avg}) - $signed({2'b00, avg_q4})
                + $signed({cfg_margin[DATA_W], cfg_margin});
        if (thr_sum[DATA_W+1])   thr_new = '0;
        else if (thr_sum[DATA_W]) thr_new = '1;
        else                     thr_new = thr_sum[DATA_W-1:0];

        thr_d  = thr_q;
        acc_d  = acc_q;
        win_d  = win_q;
        init_d = 1'b1;
        if (!adapt_en || !init_q) begin
            thr_d = cfg_thr;
            acc_d = '0;
            win_d = '0;
        end else begin
            // a full window updates thr one cycle after its last sample
            if (win_q == (AVG_LOG2+1)'(WIN_N)) begin
                thr_d = thr_new;
                acc_d = '0;
                win_d = '0;
            end
            if (accept && !range_err && is_long) begin
                acc_d = acc_d + ACC_W'(tdc_data);
                win_d = win_d + (AVG_LOG2+1)'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_valid_q  <= 1'b0;
            bit_data_q   <= 1'b0;
            code_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            idle_cnt_q   <= '0;
            thr_q        <= '0;
            acc_q        <= '0;
            win_q        <= '0;
            init_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_valid_q  <= bit_valid_d;
            bit_data_q   <= bit_data_d;
            code_err_q   <= code_err_d;
            frame_done_q <= frame_done_d;
            idle_cnt_q   <= idle_cnt_d;
            thr_q        <= thr_d;
            acc_q        <= acc_d;
            win_q        <= win_d;
            init_q       <= init_d;
        end
    end

`ifdef DMC_DEC_STATS_EN
    logic [STAT_W-1:0] stat_bits_q, stat_bits_d;
    logic [STAT_W-1:0] stat_errs_q, stat_errs_d;

    assign stat_bits = stat_bits_q;
    assign stat_errs = stat_errs_q;

    // Saturating counters of delivered bits and error pulses; clear wins
    always_comb begin
        stat_bits_d = stat_bits_q;
        stat_errs_d = stat_errs_q;
        if (stat_clr) begin
            stat_bits_d = '0;
            stat_errs_d = '0;
        end else begin
            if (bit_valid_q && bit_ready && !(&stat_bits_q))
                stat_bits_d = stat_bits_q + STAT_W'(1);
            if (code_err_q && !(&stat_errs_q))
                stat_errs_d = stat_errs_q + STAT_W'(1);
        end
    end

    // Statistics registers
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            stat_bits_q <= '0;
            stat_errs_q <= '0;
        end else begin
            stat_bits_q <= stat_bits_d;
            stat_errs_q <= stat_errs_d;
        end
    end
`endif

endmodule

// File: tb/tb_dmc_decode_adaptive.sv
// Directed testbench for dmc_decode_adaptive (DATA_W=6, AVG_LOG2=3,
// IDLE_TIMEOUT=64). Inputs change on the falling edge, outputs are
// checked on the falling edge.
module tb_dmc_decode_adaptive;

  logic       clk_i = 1'b0;
  logic       reset;
  logic       enable, adapt_en;
  logic [5:0] cfg_thr, cfg_min, cfg_max;
  logic [6:0] cfg_margin;
  logic [5:0] tdc_data;
  logic       tdc_valid, tdc_ready;
  logic       bit_data, bit_valid, bit_ready;
  logic       frame_active, frame_done, code_err;
  logic [5:0] thr_cur;
`ifdef DMC_DEC_STATS_EN
  logic       stat_clr;
  logic [1:0] stat_bits, stat_errs;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset block
  always #5 clk_i = ~clk_i;

  dmc_decode_adaptive #(
    .DATA_W(6), .AVG_LOG2(3), .TIMEOUT_W(8), .IDLE_TIMEOUT(64)
`ifdef DMC_DEC_STATS_EN
    , .STAT_W(2)
`endif
  ) dut (
    .clk_i(clk_i), .reset(reset), .enable(enable), .adapt_en(adapt_en),
    .cfg_thr(cfg_thr), .cfg_min(cfg_min), .cfg_max(cfg_max),
    .cfg_margin(cfg_margin), .tdc_data(tdc_data), .tdc_valid(tdc_valid),
    .tdc_ready(tdc_ready), .bit_data(bit_data), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .frame_active(frame_active),
    .frame_done(frame_done), .code_err(code_err), .thr_cur(thr_cur)
`ifdef DMC_DEC_STATS_EN
    , .stat_clr(stat_clr), .stat_bits(stat_bits), .stat_errs(stat_errs)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // driver: present one sample, wait for acceptance, return at the falling
  // edge after the accepting edge with tdc_valid dropped
  task automatic send(input logic [5:0] d);
    logic ok;
    @(negedge clk_i);
    tdc_data  = d;
    tdc_valid = 1'b1;
    #1;
    ok = tdc_ready;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk_i);
      #1;
      ok = tdc_ready;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(negedge clk_i);
    tdc_valid = 1'b0;
  endtask

  task automatic chk_bit(input string tag, input logic v);
    check({tag, "_valid"}, bit_valid, 1);
    check({tag, "_data"}, bit_data, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; adapt_en = 1'b0;
    cfg_thr = 6'd20; cfg_min = 6'd4; cfg_max = 6'd50; cfg_margin = 7'd0;
    tdc_data = '0; tdc_valid = 1'b0; bit_ready = 1'b1;
`ifdef DMC_DEC_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    // reset state
    check("rst_bit_valid", bit_valid, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_code_err", code_err, 0);
    check("rst_thr_cur", thr_cur, 0);
    check("rst_tdc_ready", tdc_ready, 0);
    reset = 1'b0;
    @(negedge clk_i);
    check("thr_after_rst", thr_cur, 20);

    // basic decode: 30,12,12,30 -> 1,0,1
    send(6'd30); chk_bit("t1_b0", 1); check("t1_active", frame_active, 1);
    check("t1_err0", code_err, 0);
    send(6'd12); check("t1_half_novalid", bit_valid, 0);
    send(6'd12); chk_bit("t1_b1", 0); check("t1_err1", code_err, 0);
    send(6'd30); chk_bit("t1_b2", 1); check("t1_err2", code_err, 0);

    // violation: short then long -> error, no bit; then long -> bit 1
    send(6'd12);
    send(6'd30); check("t2_viol_err", code_err, 1); check("t2_viol_novalid", bit_valid, 0);
    send(6'd30); chk_bit("t2_resync", 1); check("t2_err_clr", code_err, 0);

    // range errors leave state unchanged; bounds are inclusive; thr is strict
    send(6'd60); check("rng_hi_err", code_err, 1); check("rng_hi_novalid", bit_valid, 0);
    send(6'd2);  check("rng_lo_err", code_err, 1);
    send(6'd30); chk_bit("rng_state_kept", 1);
    send(6'd50); chk_bit("rng_max_ok", 1); check("rng_max_noerr", code_err, 0);
    send(6'd20); check("thr_eq_short", bit_valid, 0);
    send(6'd4);  chk_bit("rng_min_ok", 0);

    // adaptive threshold: eight longs of 32 -> 32 - 8 = 24
    @(negedge clk_i); adapt_en = 1'b1;
    for (int i = 0; i < 8; i++) send(6'd32);
    check("adapt_old_thr", thr_cur, 20);
    @(negedge clk_i);
    check("adapt_new_thr", thr_cur, 24);
    send(6'd22); check("adapt_22_short", bit_valid, 0);
    send(6'd22); chk_bit("adapt_22_pair", 0);
    // margin -30 saturates at 0
    cfg_margin = 7'd98;
    for (int i = 0; i < 8; i++) send(6'd32);
    check("sat_old_thr", thr_cur, 24);
    @(negedge clk_i);
    check("sat_thr_zero", thr_cur, 0);
    send(6'd5); chk_bit("sat_5_long", 1);
    adapt_en = 1'b0; cfg_margin = 7'd0;
    @(negedge clk_i);
    check("adapt_off_thr", thr_cur, 20);
    @(negedge clk_i);

    // backpressure
    bit_ready = 1'b0;
    send(6'd30); chk_bit("bp_first", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      tdc_data = 6'd12; tdc_valid = 1'b1;
      #1;
      check("bp_ready_low", tdc_ready, 0);
      chk_bit("bp_hold", 1);
    end
    bit_ready = 1'b1;
    #1;
    check("bp_ready_back", tdc_ready, 1);
    @(negedge clk_i);
    check("bp_consumed", bit_valid, 0);
    @(negedge clk_i);
    tdc_valid = 1'b0;
    chk_bit("bp_no_loss", 0);

    // idle timeout with a pending half-bit
    send(6'd30);
    send(6'd12);
    repeat (63) @(negedge clk_i);
    check("to_active_63", frame_active, 1);
    check("to_done_63", frame_done, 0);
    @(negedge clk_i);
    check("to_flush_active", frame_active, 1);
    check("to_flush_ready", tdc_ready, 0);
    @(negedge clk_i);
    check("to_done_pulse", frame_done, 1);
    check("to_active_fall", frame_active, 0);
    check("to_half_dropped", bit_valid, 0);
    @(negedge clk_i);
    check("to_done_once", frame_done, 0);

    // enable drop mid-frame, flush waits for the pending bit
    bit_ready = 1'b0;
    send(6'd30);
    enable = 1'b0;
    @(negedge clk_i);
    check("en_flush_active", frame_active, 1);
    check("en_done0", frame_done, 0);
    @(negedge clk_i);
    check("en_wait_done", frame_done, 0);
    chk_bit("en_wait_bit", 1);
    bit_ready = 1'b1;
    @(negedge clk_i);
    check("en_bit_gone", bit_valid, 0);
    check("en_done1", frame_done, 0);
    @(negedge clk_i);
    check("en_done_pulse", frame_done, 1);
    check("en_active_fall", frame_active, 0);
    @(negedge clk_i);
    check("en_done_once", frame_done, 0);
    enable = 1'b1;

    // reset mid-frame
    send(6'd30);
    send(6'd12);
    reset = 1'b1;
    #1;
    check("mr_active", frame_active, 0);
    check("mr_valid", bit_valid, 0);
    check("mr_thr", thr_cur, 0);
    @(negedge clk_i);
    check("mr_done0", frame_done, 0);
    @(negedge clk_i);
    reset = 1'b0;
    @(negedge clk_i);
    check("mr_thr_reload", thr_cur, 20);
    check("mr_done1", frame_done, 0);

`ifdef DMC_DEC_STATS_EN
    check("st_rst", stat_bits, 0);
    for (int i = 0; i < 5; i++) send(6'd30);
    @(negedge clk_i);
    check("st_sat", stat_bits, 3);
    send(6'd30);
    stat_clr = 1'b1;
    @(negedge clk_i);
    stat_clr = 1'b0;
    check("st_clr_prio", stat_bits, 0);
    send(6'd60);
    @(negedge clk_i);
    check("st_errs", stat_errs, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
